// File: rtl/car_collision.sv
// rtl/car_collision.sv - frog/car overlap detection and life/respawn state machine
module car_collision #(
  parameter int NUM_LANES     = 4,
  parameter int FIRST_CAR_ROW = 1,
  parameter int CAR_WIDTH     = 2,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 12500000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [5*NUM_LANES-1:0] i_car_x,
  input  logic [4:0]             i_frog_x,
  input  logic [4:0]             i_frog_y,
  input  logic                   i_restart,
  output logic                   o_hit,
  output logic                   o_freeze,
  output logic                   o_respawn,
  output logic [1:0]             o_lives,
  output logic                   o_game_over
);

  typedef enum logic [1:0] {
    S_PLAY      = 2'd0,
    S_HIT       = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [23:0] TIMER_LOAD = 24'(RESPAWN_TICKS - 1);
  localparam logic [1:0]  GUARD_LOAD = 2'd3;

  logic [5*NUM_LANES-1:0] car_x_q;
  logic [4:0]             frog_x_q;
  logic [4:0]             frog_y_q;

  state_t      state_q;
  logic [23:0] timer_q;
  logic [1:0]  guard_q;
  logic [1:0]  lives_q;
  logic        hit_q;
  logic        freeze_q;
  logic        respawn_q;
  logic        game_over_q;

  logic        overlap_d;
  logic        hit_valid_d;

  // Sample the sprite positions so overlap is evaluated on stable values
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      car_x_q  <= '0;
      frog_x_q <= '0;
      frog_y_q <= '0;
    end else begin
      car_x_q  <= i_car_x;
      frog_x_q <= i_frog_x;
      frog_y_q <= i_frog_y;
    end
  end

  // Frog overlaps a car when it sits on that car's lane row and inside its span (no wrap)
  always_comb begin
    logic [4:0] car;
    logic [5:0] car_end;
    overlap_d = 1'b0;
    car       = '0;
    car_end   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      car     = car_x_q[5*k +: 5];
      car_end = {1'b0, car} + 6'(CAR_WIDTH);
      if ((int'(frog_y_q) == FIRST_CAR_ROW + k) &&
          (frog_x_q >= car) && ({1'b0, frog_x_q} < car_end)) begin
        overlap_d = 1'b1;
      end
    end
    hit_valid_d = overlap_d && (guard_q == 2'd0);
  end

  // Life/respawn state machine with registered pulse and level outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= S_PLAY;
      timer_q     <= '0;
      guard_q     <= '0;
      lives_q     <= LIVES_INIT;
      hit_q       <= 1'b0;
      freeze_q    <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
      if (guard_q != 2'd0) begin
        guard_q <= guard_q - 2'd1;
      end
      case (state_q)
        S_PLAY: begin
          if (hit_valid_d) begin
            hit_q    <= 1'b1;
            freeze_q <= 1'b1;
            if (lives_q == 2'd1) begin
              lives_q     <= 2'd0;
              game_over_q <= 1'b1;
              state_q     <= S_GAME_OVER;
            end else begin
              lives_q <= lives_q - 2'd1;
              timer_q <= TIMER_LOAD;
              state_q <= S_HIT;
            end
          end
        end
        S_HIT: begin
          if (timer_q == 24'd0) begin
            respawn_q <= 1'b1;
            guard_q   <= GUARD_LOAD;
            freeze_q  <= 1'b0;
            state_q   <= S_PLAY;
          end else begin
            timer_q <= timer_q - 24'd1;
          end
        end
        S_GAME_OVER: begin
          if (i_restart) begin
            lives_q     <= LIVES_INIT;
            respawn_q   <= 1'b1;
            guard_q     <= GUARD_LOAD;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
            state_q     <= S_PLAY;
          end
        end
        default: begin
          state_q <= S_PLAY;
        end
      endcase
    end
  end

  assign o_hit       = hit_q;
  assign o_freeze    = freeze_q;
  assign o_respawn   = respawn_q;
  assign o_lives     = lives_q;
  assign o_game_over = game_over_q;

endmodule

// File: tb/tb_car_collision.sv
// tb/tb_car_collision.sv - directed scoreboard bench for car_collision
module tb_car_collision;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5*NL-1:0] car_x;
  logic [4:0]    frog_x;
  logic [4:0]    frog_y;
  logic          restart;
  logic          hit, freeze, respawn, game_over;
  logic [1:0]    lives;
  logic [5:0]    obs;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  car_collision #(
    .NUM_LANES(4), .FIRST_CAR_ROW(1), .CAR_WIDTH(2), .LIVES(3), .RESPAWN_TICKS(8)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_car_x(car_x), .i_frog_x(frog_x), .i_frog_y(frog_y),
    .i_restart(restart), .o_hit(hit), .o_freeze(freeze), .o_respawn(respawn),
    .o_lives(lives), .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  assign obs = {hit, freeze, respawn, game_over, lives};

  function automatic logic [5:0] ev(bit h, bit f, bit r, bit g, logic [1:0] l);
    return {h, f, r, g, l};
  endfunction

  task automatic set_cars(logic [4:0] c0, logic [4:0] c1, logic [4:0] c2, logic [4:0] c3);
    car_x = {c3, c2, c1, c0};
  endtask

  task automatic step(string tag, logic [5:0] e);
    exp_t x;
    exp_t got;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    assert (obs === got.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (hit,frz,resp,go,lives)", got.tag, obs, got.exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset_a", ev(0, 0, 0, 0, 2'd3));
    step("reset_b", ev(0, 0, 0, 0, 2'd3));
    rst = 1'b0;
  endtask

  task automatic run_hit(string tag, logic [1:0] lb, logic [1:0] la, bit keep);
    step({tag, "_lat"}, ev(0, 0, 0, 0, lb));
    step({tag, "_hit"}, ev(1, 1, 0, 0, la));
    if (!keep) frog_y = 5'd0;
    for (int i = 0; i < 7; i++) step({tag, "_freeze"}, ev(0, 1, 0, 0, la));
    step({tag, "_respawn"}, ev(0, 0, 1, 0, la));
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    set_cars(5'd0, 5'd0, 5'd0, 5'd0);
    frog_x = 5'd0;
    frog_y = 5'd0;

    do_reset();
    frog_x = 5'd5; frog_y = 5'd1;
    set_cars(5'd10, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 100; i++) step("idle_no_hit", ev(0, 0, 0, 0, 2'd3));

    set_cars(5'd4, 5'd0, 5'd0, 5'd0);
    run_hit("single", 2'd3, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) step("single_play", ev(0, 0, 0, 0, 2'd2));

    frog_x = 5'd6; frog_y = 5'd1;
    for (int i = 0; i < 4; i++) step("edge_right_miss", ev(0, 0, 0, 0, 2'd2));
    set_cars(5'd4, 5'd4, 5'd4, 5'd4);
    frog_x = 5'd4; frog_y = 5'd0;
    for (int i = 0; i < 4; i++) step("row0_miss", ev(0, 0, 0, 0, 2'd2));
    frog_y = 5'd5;
    for (int i = 0; i < 4; i++) step("row5_miss", ev(0, 0, 0, 0, 2'd2));
    set_cars(5'd4, 5'd0, 5'd0, 5'd0);
    frog_x = 5'd4; frog_y = 5'd1;
    run_hit("edge_left", 2'd2, 2'd1, 1'b0);

    do_reset();
    set_cars(5'd0, 5'd0, 5'd0, 5'd20);
    frog_x = 5'd20; frog_y = 5'd4;
    run_hit("lane3_x20", 2'd3, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) step("guard1", ev(0, 0, 0, 0, 2'd2));
    step("guard1_rehit", ev(1, 1, 0, 0, 2'd1));
    for (int i = 0; i < 7; i++) step("hit2_freeze", ev(0, 1, 0, 0, 2'd1));
    step("hit2_respawn", ev(0, 0, 1, 0, 2'd1));
    for (int i = 0; i < 3; i++) step("guard2", ev(0, 0, 0, 0, 2'd1));
    step("enter_game_over", ev(1, 1, 0, 1, 2'd0));
    for (int i = 0; i < 10; i++) step("game_over_hold", ev(0, 1, 0, 1, 2'd0));
    restart = 1'b1;
    step("restart", ev(0, 0, 1, 0, 2'd3));
    restart = 1'b0;
    frog_y = 5'd0;
    for (int i = 0; i < 5; i++) step("after_restart", ev(0, 0, 0, 0, 2'd3));

    set_cars(5'd4, 5'd0, 5'd0, 5'd0);
    frog_x = 5'd5; frog_y = 5'd1;
    step("midhit_lat", ev(0, 0, 0, 0, 2'd3));
    step("midhit_hit", ev(1, 1, 0, 0, 2'd2));
    for (int i = 0; i < 4; i++) step("midhit_freeze", ev(0, 1, 0, 0, 2'd2));
    rst = 1'b1;
    frog_y = 5'd0;
    step("midhit_reset", ev(0, 0, 0, 0, 2'd3));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step("midhit_no_respawn", ev(0, 0, 0, 0, 2'd3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_collision.md
# car_collision

Consumes the per-lane car x-positions from the car sprite instances (5-bit tile column, 0..20, updated at most once per 6 250 000 clocks) together with the frog's tile position. Detects frog/car overlap and runs the life/respawn state machine: decrements lives, freezes play for a fixed interval, requests a frog respawn, and declares game over. It sits between the sprite movers and the frog controller/renderer.

## Interface
- NUM_LANES, 4, number of car lanes; lane k occupies tile row FIRST_CAR_ROW + k
- FIRST_CAR_ROW, 1, tile row of lane 0
- CAR_WIDTH, 2, car length in tiles (1..4)
- LIVES, 3, lives at reset/restart (1..3)
- RESPAWN_TICKS, 12500000, freeze duration in clocks after a hit (0.5 s at 25 MHz); ≥1
- i_Clk  in  1  25 MHz clock; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_car_x  in  5*NUM_LANES  packed car columns; lane k at bits [5k+4:5k]
- i_frog_x  in  5  frog tile column
- i_frog_y  in  5  frog tile row
- i_restart  in  1  leave GAME_OVER (sampled level; acted on only in GAME_OVER)
- o_hit  out  1  one-cycle pulse on each accepted collision
- o_freeze  out  1  high in HIT and GAME_OVER; movement inputs must be ignored upstream
- o_respawn  out  1  one-cycle pulse: frog controller returns frog to start
- o_lives  out  2  remaining lives
- o_game_over  out  1  high in GAME_OVER

## Operation
- Input stage: i_car_x, i_frog_x, i_frog_y registered every clock (sample registers reset to 0).
- Overlap (combinational on registered values): frog row r = FIRST_CAR_ROW + k for some lane k < NUM_LANES, and car_x[k] ≤ frog_x < car_x[k] + CAR_WIDTH, sum computed 6 bits wide (no wrap; car at 20 with width 2 covers 20..21). Rows outside lanes never collide.
- Guard counter (2 bits): loaded with 3 when o_respawn pulses; overlap is masked while guard ≠ 0; decrements each clock to 0.
- States: PLAY, HIT, GAME_OVER.
- PLAY: unmasked overlap → o_hit pulse, o_lives − 1; if o_lives was 1 → GAME_OVER (o_lives = 0), else → HIT with timer = RESPAWN_TICKS − 1.
- HIT: overlap ignored; timer decrements; when timer = 0 → o_respawn pulse, load guard, → PLAY.
- GAME_OVER: overlap ignored; i_restart = 1 → o_lives = LIVES, o_respawn pulse, load guard, → PLAY.
- Timer 24 bits, only meaningful in HIT.

## Timing
- Reset (i_Rst high at an edge): state PLAY, o_lives = LIVES, o_hit = 0, o_respawn = 0, o_freeze = 0, o_game_over = 0, timer = 0, guard = 0. Reset overrides everything, including mid-HIT and mid-GAME_OVER.
- Latency: overlap presented on inputs before edge N → registered at N → o_hit, o_lives, o_freeze updated after edge N+1 (2 clocks).
- o_freeze rises with o_hit (same edge) when entering HIT; rises with o_game_over when entering GAME_OVER.
- HIT lasts exactly RESPAWN_TICKS clocks: o_freeze high RESPAWN_TICKS cycles, o_respawn pulses in the cycle after o_freeze falls; o_freeze falls on the same edge o_respawn rises.
- Guard covers the 3 cycles after o_respawn asserts, absorbing frog-controller update (1) plus input register (1) lag plus margin.
- Overlap persisting after guard expires causes a new hit (intended; frog respawned on a lane is a hit).
- All outputs registered; o_hit and o_respawn never high more than one consecutive cycle.

## Test plan
- Reset: assert i_Rst 2 cycles → o_lives = 3, all flags 0; release with frog (5,1), car0 at 10 → no o_hit for 100 cycles.
- Single hit (RESPAWN_TICKS = 8): car0 = 4, frog (5,1) applied before edge N → o_hit pulse after N+1, o_lives = 2, o_freeze high 8 cycles, then o_respawn 1 cycle, state PLAY.
- Edge overlap: car0 = 4, frog_x = 6 → no hit; frog_x = 4 → hit; car3 = 20, frog (20,4) → hit; frog row 0 or 5 with any car → no hit.
- Guard: keep frog (5,1) overlapping through respawn → no o_hit during 3 guard cycles, o_hit on the 4th cycle after o_respawn.
- Game over: three hits → o_lives 2,1,0; third enters GAME_OVER, o_game_over = 1, o_freeze = 1, no further o_hit; i_restart = 1 → o_lives = 3, o_respawn pulse, PLAY.
- Reset mid-HIT: i_Rst at timer = 3 → next cycle o_freeze = 0, o_lives = 3, no o_respawn pulse.
